alarm_ring_ctrl: RTL and testbench

- Consumes the 4 Hz square wave from the alarm clock's divider, together with the alarm-match pulse and the user keys.
- Drives the piezo buzzer with a gated audio tone: 0.25 s on / 0.25 s off.
- Implements ring timeout, snooze with a bounded count, and stop.
- Sits between the divider/time-compare logic and the buzzer pin and status LEDs.

---
 rtl/alarm_ring_ctrl_pkg.sv | 24 ++
 rtl/alarm_ring_ctrl_sync_edge.sv | 36 +++
 rtl/alarm_ring_ctrl.sv | 143 ++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ring_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_pkg -- shared state encoding and default timing for the alarm ringer
// Revision: 1.0
// ---------------------------------------------------------------------------
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam int TONE_HALF_DEF  = 12500;
   localparam int RING_SEC_DEF   = 60;
   localparam int SNOOZE_SEC_DEF = 300;
   localparam int MAX_SNOOZE_DEF = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ring_ctrl_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge -- 2-flop synchronizer plus edge register, one-cycle edge pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter bit RISE    = 1'b1,
   parameter bit RST_LVL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // All three stages reset to the idle level so release never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_LVL;
         sync_q <= RST_LVL;
         prev_q <= RST_LVL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse_o = RISE ? (sync_q & ~prev_q) : (~sync_q & prev_q);

endmodule
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_ring_ctrl -- gated buzzer tone with ring timeout, bounded snooze, stop
// Revision: 1.0
// ---------------------------------------------------------------------------
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int TONE_HALF  = TONE_HALF_DEF,
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
   parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_4hz,
   input  logic       alarm_trig,
   input  logic       key_snooze_n,
   input  logic       key_stop_n,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   localparam int SEC_W  = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
   localparam int TONE_W = $clog2(TONE_HALF + 1);

   localparam logic [SEC_W-1:0]  c_ring_last = SEC_W'(RING_SEC - 1);
   localparam logic [SEC_W-1:0]  c_snz_last  = SEC_W'(SNOOZE_SEC - 1);
   localparam logic [TONE_W-1:0] c_tone_last = TONE_W'(TONE_HALF - 1);
   localparam logic [1:0]        c_max_snz   = 2'(MAX_SNOOZE);

   logic tick, snz_p, stp_p;

   sync_edge #(.RISE(1'b1), .RST_LVL(1'b0)) u_sync_4hz (
      .clk(clk), .rst_n(rst_n), .d_i(clk_4hz), .pulse_o(tick));
   sync_edge #(.RISE(1'b0), .RST_LVL(1'b1)) u_sync_snz (
      .clk(clk), .rst_n(rst_n), .d_i(key_snooze_n), .pulse_o(snz_p));
   sync_edge #(.RISE(1'b0), .RST_LVL(1'b1)) u_sync_stp (
      .clk(clk), .rst_n(rst_n), .d_i(key_stop_n), .pulse_o(stp_p));

   state_t           state_q;
   logic [1:0]       q_q;
   logic [SEC_W-1:0] sec_q;
   logic             ringing_q;
   logic             snoozing_q;
   logic [1:0]       snz_cnt_q;

   // Timeouts fire on the tick that would carry sec up to its limit.
   logic q_wrap, ring_done, snz_done, snz_ok;
   assign q_wrap    = tick && (q_q == 2'd3);
   assign ring_done = q_wrap && (sec_q == c_ring_last);
   assign snz_done  = q_wrap && (sec_q == c_snz_last);
   assign snz_ok    = snz_p && (snz_cnt_q < c_max_snz);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         q_q        <= 2'd0;
         sec_q      <= '0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         snz_cnt_q  <= 2'd0;
      end else begin
         if (tick && (state_q != ST_IDLE)) begin
            q_q <= q_q + 2'd1;
            if (q_q == 2'd3)
               sec_q <= sec_q + 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (alarm_trig) begin
                  state_q   <= ST_RING;
                  ringing_q <= 1'b1;
                  snz_cnt_q <= 2'd0;
                  q_q       <= 2'd0;
                  sec_q     <= '0;
               end
            end
            ST_RING: begin
               if (stp_p || (ring_done && !snz_ok)) begin
                  state_q   <= ST_IDLE;
                  ringing_q <= 1'b0;
                  q_q       <= 2'd0;
                  sec_q     <= '0;
               end else if (snz_ok) begin
                  state_q    <= ST_SNOOZE;
                  ringing_q  <= 1'b0;
                  snoozing_q <= 1'b1;
                  snz_cnt_q  <= snz_cnt_q + 2'd1;
                  q_q        <= 2'd0;
                  sec_q      <= '0;
               end
            end
            ST_SNOOZE: begin
               if (stp_p || snz_done) begin
                  state_q    <= stp_p ? ST_IDLE : ST_RING;
                  ringing_q  <= !stp_p;
                  snoozing_q <= 1'b0;
                  q_q        <= 2'd0;
                  sec_q      <= '0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               ringing_q  <= 1'b0;
               snoozing_q <= 1'b0;
            end
         endcase
      end
   end

   // Beeps on quarters 0 and 2; the tone restarts from zero each beep.
   logic              gate;
   logic [TONE_W-1:0] tone_q;
   logic              buzzer_q;
   assign gate = (state_q == ST_RING) && !q_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_q   <= '0;
         buzzer_q <= 1'b0;
      end else if (gate) begin
         if (tone_q == c_tone_last) begin
            tone_q   <= '0;
            buzzer_q <= ~buzzer_q;
         end else begin
            tone_q <= tone_q + 1'b1;
         end
      end else begin
         tone_q   <= '0;
         buzzer_q <= 1'b0;
      end
   end

   assign buzzer     = buzzer_q;
   assign ringing    = ringing_q;
   assign snoozing   = snoozing_q;
   assign snooze_cnt = snz_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alarm_ring_ctrl -- directed stimulus with a cycle-keyed expectation queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alarm_ring_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clk_4hz = 1'b0;
   logic       alarm_trig = 1'b0;
   logic       key_snooze_n = 1'b1;
   logic       key_stop_n = 1'b1;
   logic       buzzer, ringing, snoozing;
   logic [1:0] snooze_cnt;

   alarm_ring_ctrl #(
      .TONE_HALF(4), .RING_SEC(2), .SNOOZE_SEC(1), .MAX_SNOOZE(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_4hz(clk_4hz), .alarm_trig(alarm_trig),
      .key_snooze_n(key_snooze_n), .key_stop_n(key_stop_n),
      .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
      .snooze_cnt(snooze_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 16-cycle 4 Hz stand-in: rises at the negedge where cyc%16==8, so the
   // synchronized tick is acted on at the posedge that makes cyc%16==11.
   always @(negedge clk) clk_4hz = ((cyc % 16) >= 8);

   typedef struct {
      int         at;      // -1: check immediately on async_chk
      string      name;
      logic [4:0] mask;    // {buzzer, ringing, snoozing, snooze_cnt}
      logic [4:0] exp;
   } chk_t;

   chk_t sb[$];
   int   n_checks = 0;
   int   n_err = 0;
   event async_chk;

   task automatic push(input int at, input string name, input logic [4:0] mask,
                       input logic [4:0] exp);
      chk_t c;
      c.at = at; c.name = name; c.mask = mask; c.exp = exp;
      sb.push_back(c);
   endtask

   task automatic push_st(input int at, input string name, input logic r,
                          input logic s, input logic [1:0] cnt);
      push(at, name, 5'b01111, {1'b0, r, s, cnt});
   endtask

   task automatic push_bz(input int at, input string name, input logic b);
      push(at, name, 5'b10000, {b, 4'b0000});
   endtask

   task automatic step_to(input int target);
      while (cyc != target) @(negedge clk);
   endtask

   task automatic align_tick();
      do @(negedge clk); while ((cyc % 16) != 11);
   endtask

   chk_t       mc;
   logic [4:0] act;
   initial begin
      forever begin
         @(negedge clk or async_chk);
         while (sb.size() > 0 && (sb[0].at == -1 || sb[0].at <= cyc)) begin
            mc  = sb.pop_front();
            act = {buzzer, ringing, snoozing, snooze_cnt};
            n_checks++;
            if (mc.at != -1 && mc.at < cyc) begin
               n_err++;
               $display("FAIL %s: scheduled cycle %0d passed unchecked (now %0d)",
                        mc.name, mc.at, cyc);
            end else if ((act & mc.mask) !== (mc.exp & mc.mask)) begin
               n_err++;
               $display("FAIL %s: cycle %0d buz/ring/snz/cnt got %b expected %b (mask %b)",
                        mc.name, cyc, act & mc.mask, mc.exp & mc.mask, mc.mask);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit hit before finish, errors so far %0d", n_err);
      $fatal(1, "watchdog expired");
   end

   int a, s, r, r3;
   initial begin
      #1 rst_n = 1'b0;
      step_to(4);
      rst_n = 1'b1;
      push_st(5, "reset_state", 1'b0, 1'b0, 2'd0);
      push_bz(5, "reset_buz", 1'b0);

      // Ring to timeout: 8 ticks, tone only in quarters 0 and 2.
      align_tick();
      a = cyc + 1;
      alarm_trig = 1'b1;
      push_st(a, "trig_ring", 1'b1, 1'b0, 2'd0);
      push_bz(a + 3,  "q0_pre_edge", 1'b0);
      push_bz(a + 4,  "q0_edge1", 1'b1);
      push_bz(a + 8,  "q0_edge2", 1'b0);
      push_bz(a + 12, "q0_edge3", 1'b1);
      push_bz(a + 15, "q0_last", 1'b1);
      push_bz(a + 16, "q1_forced0", 1'b0);
      push_bz(a + 24, "q1_quiet", 1'b0);
      push_bz(a + 35, "q2_edge1", 1'b1);
      push_bz(a + 39, "q2_edge2", 1'b0);
      push_bz(a + 43, "q2_edge3", 1'b1);
      push_bz(a + 47, "q2_edge4", 1'b0);
      push_bz(a + 56, "q3_quiet", 1'b0);
      push_bz(a + 67, "sec1_q0_edge", 1'b1);
      push_st(a + 126, "ring_before_to", 1'b1, 1'b0, 2'd0);
      push_st(a + 127, "ring_timeout", 1'b0, 1'b0, 2'd0);
      push_bz(a + 127, "timeout_buz", 1'b0);
      step_to(a);
      alarm_trig = 1'b0;
      step_to(a + 130);

      // First snooze and wake-up.
      align_tick();
      a = cyc + 1;
      alarm_trig = 1'b1;
      push_st(a, "trig2", 1'b1, 1'b0, 2'd0);
      step_to(a);
      alarm_trig = 1'b0;
      step_to(a + 5);
      key_snooze_n = 1'b0;
      s = a + 8;
      r = s + 55;
      push_st(s - 1, "pre_snz1", 1'b1, 1'b0, 2'd0);
      push_st(s, "snz1", 1'b0, 1'b1, 2'd1);
      push_bz(s + 1, "snz1_quiet", 1'b0);
      push_st(s + 54, "snz1_hold", 1'b0, 1'b1, 2'd1);
      push_st(s + 55, "snz1_wake", 1'b1, 1'b0, 2'd1);
      push_bz(r + 4, "rering_buz", 1'b1);
      step_to(a + 9);
      key_snooze_n = 1'b1;

      // Second snooze, then a third press at the limit is ignored.
      step_to(r + 1);
      key_snooze_n = 1'b0;
      r3 = r + 64;
      push_st(r + 4, "snz2", 1'b0, 1'b1, 2'd2);
      push_st(r3 - 1, "snz2_hold", 1'b0, 1'b1, 2'd2);
      push_st(r3, "snz2_wake", 1'b1, 1'b0, 2'd2);
      step_to(r + 5);
      key_snooze_n = 1'b1;
      step_to(r3 + 2);
      key_snooze_n = 1'b0;
      push_st(r3 + 6, "snz3_ignored", 1'b1, 1'b0, 2'd2);
      push_st(r3 + 20, "snz3_still", 1'b1, 1'b0, 2'd2);
      step_to(r3 + 6);
      key_snooze_n = 1'b1;
      step_to(r3 + 30);
      key_stop_n = 1'b0;
      push_st(r3 + 32, "pre_stop", 1'b1, 1'b0, 2'd2);
      push_st(r3 + 33, "stop", 1'b0, 1'b0, 2'd2);
      push_bz(r3 + 34, "stop_buz", 1'b0);
      step_to(r3 + 34);
      key_stop_n = 1'b1;

      // Trigger ignored in SNOOZE; stop+snooze together go to IDLE.
      align_tick();
      a = cyc + 1;
      alarm_trig = 1'b1;
      push_st(a, "trig4_clr", 1'b1, 1'b0, 2'd0);
      step_to(a);
      alarm_trig = 1'b0;
      step_to(a + 1);
      key_snooze_n = 1'b0;
      push_st(a + 4, "snz4", 1'b0, 1'b1, 2'd1);
      step_to(a + 5);
      key_snooze_n = 1'b1;
      step_to(a + 20);
      alarm_trig = 1'b1;
      r = a + 63;
      push_st(a + 22, "trig_in_snz", 1'b0, 1'b1, 2'd1);
      push_st(r, "snz4_wake", 1'b1, 1'b0, 2'd1);
      step_to(a + 21);
      alarm_trig = 1'b0;
      step_to(r + 2);
      key_snooze_n = 1'b0;
      key_stop_n = 1'b0;
      push_st(r + 5, "stop_snz_same", 1'b0, 1'b0, 2'd1);
      push_st(r + 8, "stop_snz_hold", 1'b0, 1'b0, 2'd1);
      step_to(r + 6);
      key_snooze_n = 1'b1;
      key_stop_n = 1'b1;
      step_to(r + 20);
      key_snooze_n = 1'b0;
      key_stop_n = 1'b0;
      push_st(r + 25, "idle_keys", 1'b0, 1'b0, 2'd1);
      step_to(r + 26);
      key_snooze_n = 1'b1;
      key_stop_n = 1'b1;

      // Asynchronous reset while the buzzer is high.
      align_tick();
      a = cyc + 1;
      alarm_trig = 1'b1;
      push_st(a, "trig6", 1'b1, 1'b0, 2'd0);
      push_bz(a + 5, "pre_rst_buz", 1'b1);
      step_to(a);
      alarm_trig = 1'b0;
      step_to(a + 5);
      #2 rst_n = 1'b0;
      #1;
      push_st(-1, "async_rst", 1'b0, 1'b0, 2'd0);
      push_bz(-1, "async_rst_buz", 1'b0);
      ->async_chk;
      step_to(a + 7);
      rst_n = 1'b1;
      push_st(a + 8, "post_rst", 1'b0, 1'b0, 2'd0);
      push_bz(a + 8, "post_rst_buz", 1'b0);
      push_st(a + 30, "post_rst_quiet", 1'b0, 1'b0, 2'd0);
      push_bz(a + 30, "post_rst_quiet_buz", 1'b0);
      step_to(a + 32);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d scheduled checks never reached, expected 0", sb.size());
         n_checks += sb.size();
         n_err += sb.size();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
